// File: rtl/piece_scheduler.sv
// rtl/piece_scheduler.sv - 7-bag tetromino scheduler with current/next bags, preview and bag fetch/validation.
// Optional PIECE_HOLD_EN adds a single-slot hold with one hold per dealt piece.
module piece_scheduler #(
  parameter int PREVIEW_N   = 3,
  parameter int BAG_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   bag_newbag,
  input  logic                   bag_ready,
  input  logic [20:0]            bag_pieces,
  input  logic                   pop,
  output logic                   piece_valid,
  output logic [2:0]             piece,
  output logic [3*PREVIEW_N-1:0] preview,
  output logic [PREVIEW_N-1:0]   preview_valid,
`ifdef PIECE_HOLD_EN
  input  logic                   hold_req,
  output logic [2:0]             hold_piece,
  output logic                   hold_valid,
`endif
  output logic                   timeout_err
);

  typedef enum logic [1:0] {REQ_CUR, REQ_NXT, RUN, REFILL} state_t;
  typedef enum logic [1:0] {F_ISSUE, F_LOW, F_HIGH} fetch_t;

  localparam logic [7:0] TMO_LAST = 8'(BAG_TIMEOUT - 1);

  state_t      state_q, state_d;
  fetch_t      fph_q, fph_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        newbag_q, newbag_d;
  logic        terr_q, terr_d;
  logic [20:0] cur_bag_q, cur_bag_d, nxt_bag_q, nxt_bag_d;
  logic [2:0]  idx_q, idx_d;
  logic        cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic        got, good, take, adv, hold_adv, hold_swap;
`ifdef PIECE_HOLD_EN
  logic [2:0]  hold_piece_q, hold_piece_d;
  logic        hold_valid_q, hold_valid_d, hold_lock_q, hold_lock_d;
`endif

  function automatic logic [2:0] code_at(input logic [20:0] bag, input logic [3:0] k);
    logic [20:0] sh;
    sh = bag >> ({2'b00, k} * 6'd3);
    return sh[2:0];
  endfunction

  function automatic logic has_seven(input logic [20:0] bag);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 7; k++)
      if (code_at(bag, 4'(k)) == 3'd7) bad = 1'b1;
    return bad;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= REQ_CUR;
      fph_q     <= F_ISSUE;
      cnt_q     <= '0;
      newbag_q  <= 1'b0;
      terr_q    <= 1'b0;
      cur_bag_q <= '0;
      nxt_bag_q <= '0;
      idx_q     <= '0;
      cur_v_q   <= 1'b0;
      nxt_v_q   <= 1'b0;
`ifdef PIECE_HOLD_EN
      hold_piece_q <= '0;
      hold_valid_q <= 1'b0;
      hold_lock_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fph_q     <= fph_d;
      cnt_q     <= cnt_d;
      newbag_q  <= newbag_d;
      terr_q    <= terr_d;
      cur_bag_q <= cur_bag_d;
      nxt_bag_q <= nxt_bag_d;
      idx_q     <= idx_d;
      cur_v_q   <= cur_v_d;
      nxt_v_q   <= nxt_v_d;
`ifdef PIECE_HOLD_EN
      hold_piece_q <= hold_piece_d;
      hold_valid_q <= hold_valid_d;
      hold_lock_q  <= hold_lock_d;
`endif
    end
  end

  // A hold on an empty slot consumes the piece exactly like pop; a hold on a full slot swaps in place.
`ifdef PIECE_HOLD_EN
  assign hold_adv  = hold_req && cur_v_q && !hold_lock_q && !pop && !hold_valid_q;
  assign hold_swap = hold_req && cur_v_q && !hold_lock_q && !pop && hold_valid_q;
`else
  assign hold_adv  = 1'b0;
  assign hold_swap = 1'b0;
`endif
  assign take = pop && cur_v_q;
  assign adv  = take || hold_adv;

  always_comb begin
    state_d   = state_q;
    fph_d     = fph_q;
    cnt_d     = cnt_q;
    newbag_d  = 1'b0;
    terr_d    = terr_q;
    cur_bag_d = cur_bag_q;
    nxt_bag_d = nxt_bag_q;
    idx_d     = idx_q;
    cur_v_d   = cur_v_q;
    nxt_v_d   = nxt_v_q;
    got       = 1'b0;
`ifdef PIECE_HOLD_EN
    hold_piece_d = hold_piece_q;
    hold_valid_d = hold_valid_q;
    hold_lock_d  = hold_lock_q;
`endif
    if (state_q != RUN) begin
      case (fph_q)
        F_ISSUE: begin
          newbag_d = 1'b1;
          fph_d    = F_LOW;
          cnt_d    = '0;
        end
        F_LOW, F_HIGH: begin
          if (fph_q == F_HIGH && bag_ready) begin
            got   = 1'b1;
            fph_d = F_ISSUE;
            cnt_d = '0;
          end else if (cnt_q == TMO_LAST) begin
            terr_d = 1'b1;
            fph_d  = F_ISSUE;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (fph_q == F_LOW && !bag_ready) fph_d = F_HIGH;
          end
        end
        default: fph_d = F_ISSUE;
      endcase
    end
    good = got && !has_seven(bag_pieces);

    case (state_q)
      REQ_CUR: begin
        if (good) begin
          cur_bag_d = bag_pieces;
          cur_v_d   = 1'b1;
          idx_d     = '0;
          state_d   = REQ_NXT;
        end
      end
      REQ_NXT, REFILL: begin
        // A starved deal (or last piece taken this very cycle) promotes the arriving bag straight to current.
        if (good && (!cur_v_q || (adv && idx_q == 3'd6))) begin
          cur_bag_d = bag_pieces;
          cur_v_d   = 1'b1;
          idx_d     = '0;
          nxt_v_d   = 1'b0;
          state_d   = REQ_NXT;
        end else begin
          if (good) begin
            nxt_bag_d = bag_pieces;
            nxt_v_d   = 1'b1;
            state_d   = RUN;
          end
          if (adv) begin
            if (idx_q != 3'd6) idx_d = idx_q + 3'd1;
            else               cur_v_d = 1'b0;
          end
        end
      end
      default: begin
        if (adv) begin
          if (idx_q != 3'd6) begin
            idx_d = idx_q + 3'd1;
          end else begin
            cur_bag_d = nxt_bag_q;
            idx_d     = '0;
            nxt_v_d   = 1'b0;
            state_d   = REFILL;
            fph_d     = F_ISSUE;
            cnt_d     = '0;
          end
        end
      end
    endcase

`ifdef PIECE_HOLD_EN
    for (int k = 0; k < 7; k++)
      if (hold_swap && idx_q == 3'(k)) cur_bag_d[3*k +: 3] = hold_piece_q;
    if (hold_adv || hold_swap) begin
      hold_piece_d = piece;
      hold_valid_d = 1'b1;
      hold_lock_d  = 1'b1;
    end
    if (take) hold_lock_d = 1'b0;
`endif
  end

  always_comb begin
    bag_newbag    = newbag_q;
    timeout_err   = terr_q;
    piece_valid   = cur_v_q;
    piece         = code_at(cur_bag_q, {1'b0, idx_q});
    preview       = '0;
    preview_valid = '0;
    for (int j = 0; j < PREVIEW_N; j++) begin
      if ({1'b0, idx_q} + 4'(j + 1) < 4'd7) begin
        preview_valid[j] = cur_v_q;
        if (cur_v_q) preview[3*j +: 3] = code_at(cur_bag_q, {1'b0, idx_q} + 4'(j + 1));
      end else begin
        preview_valid[j] = nxt_v_q;
        if (nxt_v_q) preview[3*j +: 3] = code_at(nxt_bag_q, {1'b0, idx_q} + 4'(j + 1) - 4'd7);
      end
    end
  end

`ifdef PIECE_HOLD_EN
  assign hold_piece = hold_piece_q;
  assign hold_valid = hold_valid_q;
`endif

endmodule

// File: tb/tb_piece_scheduler.sv
// tb/tb_piece_scheduler.sv - directed bench for piece_scheduler with a randombag model.
module tb_piece_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bag_newbag;
  logic        bag_ready;
  logic [20:0] bag_pieces;
  logic        pop = 1'b0;
  logic        piece_valid;
  logic [2:0]  piece;
  logic [8:0]  preview;
  logic [2:0]  preview_valid;
  logic        timeout_err;
`ifdef PIECE_HOLD_EN
  logic        hold_req = 1'b0;
  logic [2:0]  hold_piece;
  logic        hold_valid;
`endif

  int checks = 0;
  int errors = 0;

  int lo_dly = 5, hi_dly = 20;
  bit hang = 1'b0;
  logic [20:0] bags [0:7];
  int ptr, mcnt;
  bit mbusy;

  piece_scheduler #(.PREVIEW_N(3), .BAG_TIMEOUT(255)) dut (
    .clk(clk), .reset(rst), .bag_newbag(bag_newbag), .bag_ready(bag_ready),
    .bag_pieces(bag_pieces), .pop(pop), .piece_valid(piece_valid), .piece(piece),
    .preview(preview), .preview_valid(preview_valid),
`ifdef PIECE_HOLD_EN
    .hold_req(hold_req), .hold_piece(hold_piece), .hold_valid(hold_valid),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // randombag model: done flag drops lo_dly cycles after a request, bag arrives lo_dly+hi_dly cycles after it
  initial begin
    bag_ready = 1'b1; bag_pieces = '0; ptr = 0; mcnt = 0; mbusy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bag_ready = 1'b1; ptr = 0; mcnt = 0; mbusy = 1'b0;
      end else if (bag_newbag) begin
        mbusy = 1'b1; mcnt = 0;
      end else if (mbusy) begin
        mcnt++;
        if (mcnt == lo_dly) bag_ready = 1'b0;
        if (mcnt >= lo_dly + hi_dly && !hang) begin
          bag_pieces = bags[ptr % 8]; ptr++; bag_ready = 1'b1; mbusy = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] mk(input bit rev);
    logic [20:0] b;
    b = '0;
    for (int k = 0; k < 7; k++) b[3*k +: 3] = rev ? 3'(6 - k) : 3'(k);
    return b;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int c;
    c = 0;
    while (!piece_valid && c < max) begin tick(); c++; end
    check(tag, 32'(piece_valid), 32'd1);
  endtask

  initial begin
    int n, mask, bad, pulses;
    bit prev;
    for (int i = 0; i < 8; i++) bags[i] = mk(i[0]);

    // T1: reset state, first deal, preview across the bag boundary
    tick(); tick();
    check("rst_valid", 32'(piece_valid), 0);
    check("rst_piece", 32'(piece), 0);
    check("rst_preview", 32'(preview), 0);
    check("rst_pvalid", 32'(preview_valid), 0);
    check("rst_newbag", 32'(bag_newbag), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0;
    wait_valid("t1_valid", 200);
    check("t1_piece0", 32'(piece), 0);
    check("t1_preview0", 32'(preview), 32'({3'd3, 3'd2, 3'd1}));
    check("t1_pvalid0", 32'(preview_valid), 32'h7);
    repeat (40) tick();
    pop = 1'b1; repeat (5) tick(); pop = 1'b0;
    check("t1_piece5", 32'(piece), 5);
    check("t1_preview5", 32'(preview), 32'({3'd5, 3'd6, 3'd6}));
    check("t1_pvalid5", 32'(preview_valid), 32'h7);
    pop = 1'b1; repeat (2) tick(); pop = 1'b0;
    check("t1_nextbag", 32'(piece), 6);

    // T2: pop every cycle, fast bags
    lo_dly = 2; hi_dly = 8;
    do_reset();
    pop = 1'b1; n = 0; mask = 0; bad = 0; prev = 1'b0;
    for (int c = 0; c < 400 && n < 21; c++) begin
      tick();
      if (prev && !piece_valid && (n % 7) != 0) bad++;
      prev = piece_valid;
      if (piece_valid) begin
        mask |= (1 << piece); n++;
        if (n % 7 == 0) begin
          check($sformatf("t2_perm%0d", n / 7), mask, 32'h7f);
          mask = 0;
        end
      end
    end
    pop = 1'b0;
    check("t2_count", n, 21);
    check("t2_drop", bad, 0);

    // T3: a bag holding code 7 is discarded and refetched
    bags[0] = mk(1'b0) | (21'd7 << 9);
    bags[1] = mk(1'b1);
    do_reset();
    pulses = 0;
    for (int c = 0; c < 300 && !piece_valid; c++) begin
      tick();
      if (!piece_valid && bag_newbag) pulses++;
    end
    check("t3_valid", 32'(piece_valid), 1);
    check("t3_pulses", pulses, 2);
    check("t3_piece", 32'(piece), 6);
    for (int i = 0; i < 8; i++) bags[i] = mk(i[0]);

    // T4: bag never arrives -> timeout at 255 cycles and a new request
    hang = 1'b1;
    do_reset();
    for (int c = 0; c < 10 && !bag_newbag; c++) tick();
    check("t4_first_pulse", 32'(bag_newbag), 1);
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 254) check("t4_not_yet", 32'(timeout_err), 0);
      if (k == 255) check("t4_timeout", 32'(timeout_err), 1);
      if (k == 256) check("t4_repulse", 32'(bag_newbag), 1);
    end
    hang = 1'b0;
    wait_valid("t4_recover", 100);
    check("t4_sticky", 32'(timeout_err), 1);

    // T5: asynchronous reset while refilling
    do_reset();
    wait_valid("t5_valid", 100);
    repeat (30) tick();
    pop = 1'b1; repeat (7) tick(); pop = 1'b0;
    repeat (3) tick();
    check("t5_refill_piece", 32'(piece), 6);
    check("t5_refill_pvalid", 32'(preview_valid), 32'h7);
    #3 rst = 1'b1;
    #1;
    check("t5_valid0", 32'(piece_valid), 0);
    check("t5_piece0", 32'(piece), 0);
    check("t5_preview0", 32'(preview), 0);
    check("t5_pvalid0", 32'(preview_valid), 0);
    check("t5_newbag0", 32'(bag_newbag), 0);
    tick(); rst = 1'b0;
    tick();
    check("t5_first_pulse", 32'(bag_newbag), 1);

`ifdef PIECE_HOLD_EN
    // T6: hold into an empty slot, locked re-hold, then swap
    do_reset();
    wait_valid("t6_valid", 100);
    repeat (30) tick();
    pop = 1'b1; repeat (2) tick(); pop = 1'b0;
    check("t6_piece2", 32'(piece), 2);
    hold_req = 1'b1; tick(); hold_req = 1'b0;
    check("t6_hold_piece", 32'(hold_piece), 2);
    check("t6_hold_valid", 32'(hold_valid), 1);
    check("t6_advance", 32'(piece), 3);
    hold_req = 1'b1; tick(); hold_req = 1'b0;
    check("t6_locked_piece", 32'(piece), 3);
    check("t6_locked_hold", 32'(hold_piece), 2);
    pop = 1'b1; tick(); pop = 1'b0;
    hold_req = 1'b1; tick(); hold_req = 1'b0;
    check("t6_swap_piece", 32'(piece), 2);
    check("t6_swap_hold", 32'(hold_piece), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
